// File: rtl/fractal_iter_if.sv
// Request/result bundle between a point scheduler and one fractal_iter engine.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. A source raises valid only with stable
// payload and holds valid and payload unchanged until the transfer edge.
// Ready never depends combinationally on valid.
interface fractal_iter_if #(
  parameter int FP_WIDTH = 25,
  parameter int ITERW    = 8
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic signed [FP_WIDTH-1:0] re;
  logic signed [FP_WIDTH-1:0] im;
  logic [1:0]                 mode;
  logic [ITERW-1:0]           iter_max;
  logic signed [FP_WIDTH-1:0] jr;
  logic signed [FP_WIDTH-1:0] ji;
  logic                       out_valid;
  logic                       out_ready;
  logic [ITERW-1:0]           iter;
  logic                       escaped;
  logic                       busy;

  modport master (
    output in_valid, re, im, mode, iter_max, jr, ji, out_ready,
    input  in_ready, out_valid, iter, escaped, busy
  );

  modport slave (
    input  in_valid, re, im, mode, iter_max, jr, ji, out_ready,
    output in_ready, out_valid, iter, escaped, busy
  );
endinterface

// File: rtl/fractal_iter.sv
// Fixed-point escape-time iterator for one complex point (Mandelbrot, Julia,
// Burning Ship). One shared signed multiplier is time-multiplexed across the
// x*x, y*y and x*y steps; multiplier overflow is treated as escape.
module fractal_iter #(
  parameter int FP_WIDTH = 25,
  parameter int FP_INT   = 4,
  parameter int ITERW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  fractal_iter_if.slave    bus,
  output logic [2:0]       dbg_state
);
  localparam int FB = FP_WIDTH - FP_INT;
  // 4.0 in FP_WIDTH+1 bits, compared against |z|^2.
  localparam logic signed [FP_WIDTH:0] FOUR = {{(FP_INT-2){1'b0}}, 3'b100, {FB{1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0, SQ_X = 3'd1, SQ_Y = 3'd2, TEST = 3'd3, XY = 3'd4, UPD = 3'd5, DONE = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic signed [FP_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic signed [FP_WIDTH-1:0] x2_q, x2_d, y2_q, y2_d, xy_q, xy_d;
  logic signed [FP_WIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
  logic [ITERW-1:0]           iter_q, iter_d, iter_max_q, iter_max_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       ovf_q, ovf_d, escaped_q, escaped_d;

  logic signed [FP_WIDTH-1:0]   op_a, op_b, mul_res;
  logic signed [2*FP_WIDTH-1:0] prod;
  logic                         mul_ovf;
  logic                         unused_prod_lsb;
  logic signed [FP_WIDTH:0]     mag;

  // Pick multiplier operands for the current step; Burning Ship folds x*y onto |x|*|y|.
  always_comb begin
    op_a = x_q;
    op_b = x_q;
    if (state_q == SQ_Y) begin
      op_a = y_q;
      op_b = y_q;
    end else if (state_q == XY) begin
      op_a = (mode_q == 2'd2 && x_q[FP_WIDTH-1]) ? -x_q : x_q;
      op_b = (mode_q == 2'd2 && y_q[FP_WIDTH-1]) ? -y_q : y_q;
    end
  end

  // Full product, arithmetic shift by FB (floor), overflow when dropped top bits are not sign copies.
  always_comb begin
    prod            = op_a * op_b;
    mul_res         = prod[FB +: FP_WIDTH];
    mul_ovf         = (prod[2*FP_WIDTH-1 : FB+FP_WIDTH-1] != {(FP_INT+1){prod[FB+FP_WIDTH-1]}});
    unused_prod_lsb = ^prod[FB-1:0];
    mag             = {x2_q[FP_WIDTH-1], x2_q} + {y2_q[FP_WIDTH-1], y2_q};
  end

  // Next-state and datapath updates for the iteration sequencer.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    x2_d       = x2_q;
    y2_d       = y2_q;
    xy_d       = xy_q;
    cr_d       = cr_q;
    ci_d       = ci_q;
    iter_d     = iter_q;
    iter_max_d = iter_max_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    escaped_d  = escaped_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mode_d     = bus.mode;
          iter_max_d = bus.iter_max;
          iter_d     = '0;
          ovf_d      = 1'b0;
          escaped_d  = 1'b0;
          if (bus.mode == 2'd1) begin
            cr_d = bus.jr;
            ci_d = bus.ji;
            x_d  = bus.re;
            y_d  = bus.im;
          end else begin
            cr_d = bus.re;
            ci_d = bus.im;
            x_d  = '0;
            y_d  = '0;
          end
          state_d = SQ_X;
        end
      end
      SQ_X: begin
        x2_d    = mul_res;
        ovf_d   = ovf_q | mul_ovf;
        state_d = SQ_Y;
      end
      SQ_Y: begin
        y2_d    = mul_res;
        ovf_d   = ovf_q | mul_ovf;
        state_d = TEST;
      end
      TEST: begin
        if (ovf_q || (mag > FOUR)) begin
          escaped_d = 1'b1;
          state_d   = DONE;
        end else if (iter_q == iter_max_q) begin
          escaped_d = 1'b0;
          state_d   = DONE;
        end else begin
          state_d = XY;
        end
      end
      XY: begin
        xy_d    = mul_res;
        ovf_d   = ovf_q | mul_ovf;
        state_d = UPD;
      end
      UPD: begin
        x_d     = x2_q - y2_q + cr_q;
        y_d     = (xy_q <<< 1) + ci_q;
        iter_d  = iter_q + ITERW'(1);
        state_d = SQ_X;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any point in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      xy_q       <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      iter_q     <= '0;
      iter_max_q <= '0;
      mode_q     <= '0;
      ovf_q      <= 1'b0;
      escaped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x2_q       <= x2_d;
      y2_q       <= y2_d;
      xy_q       <= xy_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      iter_q     <= iter_d;
      iter_max_q <= iter_max_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      escaped_q  <= escaped_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.iter      = iter_q;
  assign bus.escaped   = escaped_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_fractal_iter.sv
// Directed bench for fractal_iter: hand-computed escape counts, latency,
// backpressure, reset abort and input latching.
module tb_fractal_iter;
  localparam int FP_WIDTH = 25;
  localparam int FP_INT   = 4;
  localparam int ITERW    = 8;
  localparam int ONE      = 1 << (FP_WIDTH - FP_INT);

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_cmp;
  int         n_err;

  fractal_iter_if #(.FP_WIDTH(FP_WIDTH), .ITERW(ITERW)) bus ();

  fractal_iter #(.FP_WIDTH(FP_WIDTH), .FP_INT(FP_INT), .ITERW(ITERW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [FP_WIDTH-1:0] fp(input int v);
    return FP_WIDTH'(v);
  endfunction

  // Present a point, accept it, then scramble all inputs so only latched values matter.
  task automatic start_point(input logic [1:0] m, input int r, input int i, input int j_r,
                             input int j_i, input logic [ITERW-1:0] imax);
    @(negedge clk);
    bus.mode     = m;
    bus.re       = fp(r);
    bus.im       = fp(i);
    bus.jr       = fp(j_r);
    bus.ji       = fp(j_i);
    bus.iter_max = imax;
    bus.in_valid = 1'b1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode     = m ^ 2'd2;
    bus.iter_max = ~imax;
    bus.re       = fp(3 * ONE);
    bus.im       = fp(-3 * ONE);
    bus.jr       = fp(ONE);
    bus.ji       = fp(-ONE);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    check("busy_high", 32'(bus.busy), 32'd1);
  endtask

  // Wait for out_valid; cyc is the cycle index where the accept edge is cycle 0.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_point(input string tag, input logic [1:0] m, input int r, input int i,
                           input int j_r, input int j_i, input logic [ITERW-1:0] imax,
                           input int exp_iter, input logic exp_esc);
    int cyc;
    start_point(m, r, i, j_r, j_i, imax);
    wait_done(cyc);
    check({tag, "_iter"}, 32'(bus.iter), 32'(exp_iter));
    check({tag, "_esc"}, 32'(bus.escaped), 32'(exp_esc));
    check({tag, "_lat"}, 32'(cyc), 32'(4 + 5 * exp_iter));
    release_out();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_iter"}, 32'(bus.iter), 32'd0);
    check({tag, "_esc"}, 32'(bus.escaped), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode = 2'd0;
    bus.iter_max = '0;
    bus.re = '0;
    bus.im = '0;
    bus.jr = '0;
    bus.ji = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    // Escape-time vectors
    run_point("m0_origin",   2'd0, 0, 0, 0, 0, 8'd10, 10, 1'b0);
    run_point("m0_2_2",      2'd0, 2 * ONE, 2 * ONE, 0, 0, 8'd255, 1, 1'b1);
    run_point("m0_bound",    2'd0, -2 * ONE, 0, 0, 0, 8'd20, 20, 1'b0);
    run_point("m0_m1m1",     2'd0, -ONE, -ONE, 0, 0, 8'd50, 3, 1'b1);
    run_point("m2_m1m1",     2'd2, -ONE, -ONE, 0, 0, 8'd50, 50, 1'b0);
    run_point("m0_ovf",      2'd0, 7 * ONE, 7 * ONE, 0, 0, 8'd30, 1, 1'b1);
    run_point("m1_1p5",      2'd1, 3 * ONE / 2, 0, 0, 0, 8'd10, 1, 1'b1);
    run_point("m1_0p5",      2'd1, ONE / 2, 0, 0, 0, 8'd15, 15, 1'b0);
    run_point("m3_as_m0",    2'd3, 2 * ONE, 2 * ONE, 0, 0, 8'd255, 1, 1'b1);
    run_point("m0_imax0",    2'd0, 2 * ONE, 2 * ONE, 0, 0, 8'd0, 0, 1'b0);
    run_point("m1_imax0",    2'd1, 2 * ONE, 2 * ONE, 0, 0, 8'd0, 0, 1'b1);
    run_point("m1_jc",       2'd1, 0, 0, 2 * ONE, 2 * ONE, 8'd40, 1, 1'b1);

    // Backpressure: result held stable for 20 cycles with out_ready low
    start_point(2'd0, -ONE, -ONE, 0, 0, 8'd50);
    wait_done(cyc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_iter", 32'(bus.iter), 32'd3);
      check("bp_esc", 32'(bus.escaped), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    release_out();

    // Reset mid-iteration, then in DONE
    start_point(2'd0, 0, 0, 0, 0, 8'd10);
    repeat (12) @(negedge clk);
    pulse_reset();
    start_point(2'd0, 2 * ONE, 2 * ONE, 0, 0, 8'd255);
    wait_done(cyc);
    check("pre_rst_iter", 32'(bus.iter), 32'd1);
    pulse_reset();
    @(negedge clk);
    check("post_rst_idle_valid", 32'(bus.out_valid), 32'd0);
    run_point("after_rst",   2'd0, -ONE, -ONE, 0, 0, 8'd50, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fractal_iter.md
# fractal_iter

Parametrised fixed-point escape-time iterator for one complex point. It is the next-generation per-pixel engine for the fractal renderers and supports three modes: Mandelbrot, Julia and Burning Ship. Maximum iterations and the Julia constant are set at run time. Overflow is detected and treated as escape, and input and output both use valid/ready handshakes so a scheduler can feed several instances and absorb backpressure. The multiplier is internal, so no external multiply block is needed.

## Interface
- FP_WIDTH, 25, total fixed-point width (signed two's complement)
- FP_INT, 4, integer bits including sign; fractional bits FB = FP_WIDTH-FP_INT
- ITERW, 8, width of iteration count and iter_max
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  point request valid
- in_ready  out  1  block can accept a point (high only in IDLE)
- re, im  in  FP_WIDTH signed  point coordinate
- mode  in  2  0 Mandelbrot, 1 Julia, 2 Burning Ship, 3 treated as 0
- iter_max  in  ITERW  iteration limit
- jr, ji  in  FP_WIDTH signed  Julia constant
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- iter  out  ITERW  completed iterations
- escaped  out  1  1 = escaped or overflowed, 0 = hit iter_max
- busy  out  1  high in any state other than IDLE

## Operation
- Accept happens when in_valid && in_ready. At that point mode, iter_max, re, im, jr and ji are latched, and later input changes are ignored until the next accept.
  - Modes 0 and 2: c = (re, im), z0 = 0.
  - Mode 1: c = (jr, ji), z0 = (re, im).
- iter is cleared to 0 on accept.
- Multiply: the full 2*FP_WIDTH signed product is shifted arithmetically right by FB and truncated toward minus infinity. The ovf flag is set if the discarded upper bits are not a sign extension of the result.
- FSM states and transitions:
  - IDLE: in_ready=1. On accept, go to SQ_X.
  - SQ_X: x2 <= x*x, accumulate ovf. Go to SQ_Y.
  - SQ_Y: y2 <= y*y, accumulate ovf. Go to TEST.
  - TEST, evaluated in priority order:
    - If ovf, or x2+y2 > 4.0 (sum computed in FP_WIDTH+1 bits, compared against 4<<FB): go to DONE with escaped=1.
    - Else if iter == iter_max: go to DONE with escaped=0.
    - Else: go to XY.
  - XY: xy <= a*b, where a=x and b=y in modes 0/1, and a=|x| and b=|y| in mode 2. Accumulate ovf. Go to UPD.
  - UPD: x <= x2 - y2 + cr; y <= (xy<<1) + ci; iter <= iter+1. Go to SQ_X.
    - Add/shift results wrap modulo 2^FP_WIDTH. Only multiplier overflow is flagged.
  - DONE: out_valid=1; iter and escaped are stable. When out_ready is high, go to IDLE.
- ovf is cleared on accept.
- The escape boundary is strict: |z|^2 == 4.0 does not escape.
- iter_max=0: the point gets a single TEST on z0 and returns iter=0. In modes 0/2 it returns escaped=0. In mode 1 it returns escaped=1 if |z0|^2 > 4.
- rst at any cycle, including mid-iteration and in DONE with out_valid high:
  - state becomes IDLE next cycle.
  - Outputs reset to in_ready=1, out_valid=0, busy=0, iter=0, escaped=0.
  - No result is emitted for the aborted point.

## Timing
- Accept edge is cycle 0.
- out_valid first high in cycle 4+5n, where n is the returned iter (3 cycles SQ_X/SQ_Y/TEST, plus 5 per completed iteration).
- in_ready is low from cycle 1 until the cycle after the output handshake.
- Output handshake: when out_valid && out_ready in cycle t, in_ready=1 and out_valid=0 in cycle t+1. There is no combinational ready-to-ready path, so back-to-back throughput is one point per 5+5n cycles minimum.
- out_valid, iter and escaped stay stable while out_ready is low, for any number of cycles.
- busy = !in_ready.

## Test plan
- Mode 0, c=(0,0), iter_max=10 -> iter=10, escaped=0, out_valid at cycle 54.
- Mode 0, c=(2.0,2.0), iter_max=255 -> iter=1, escaped=1, out_valid at cycle 9.
  - Mode 0, c=(-2.0,0), iter_max=20 -> iter=20, escaped=0 (|z|^2==4 boundary).
- Mode 0, c=(-1,-1), iter_max=50 -> iter=3, escaped=1.
  - Mode 2, same c -> iter=50, escaped=0 (fixed point at (-1,1)).
- Overflow: mode 0, c=(7.0,7.0) -> iter=1, escaped=1 (x*x=49 overflows ±8 range).
  - Mode 1, jr=ji=0, z0=(1.5,0) -> iter=1, escaped=1.
  - Mode 1, z0=(0.5,0) -> iter=iter_max, escaped=0.
- Backpressure and reset:
  - Hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0.
  - Pulse out_ready -> in_ready=1 next cycle.
  - Assert rst mid-iteration and while in DONE -> in_ready=1, out_valid=0, iter=0 next cycle.
  - Next point after reset computes correctly.
- Latching: change mode, iter_max and jr/ji during a calculation -> result matches the values latched at accept.
